// File: rtl/otter_cu_fsm_pkg.sv
// Shared constants for the Otter multicycle control unit: opcodes, state
// encoding, immediate-select codes and the instruction class produced by the
// opcode decoder.
package otter_cu_fsm_pkg;

  // RV32I major opcodes (instr[6:0])
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_SYS    = 7'b1110011;

  // Sequencer state encoding; codes 5..7 are unused and recover to ST_INIT
  localparam logic [2:0] ST_INIT  = 3'd0;
  localparam logic [2:0] ST_FETCH = 3'd1;
  localparam logic [2:0] ST_EXEC  = 3'd2;
  localparam logic [2:0] ST_WB    = 3'd3;
  localparam logic [2:0] ST_INTR  = 3'd4;

  // Immediate generator output select
  localparam int unsigned IMM_W = 3;
  localparam logic [IMM_W-1:0] IMM_SEL_I    = 3'd0;
  localparam logic [IMM_W-1:0] IMM_SEL_S    = 3'd1;
  localparam logic [IMM_W-1:0] IMM_SEL_B    = 3'd2;
  localparam logic [IMM_W-1:0] IMM_SEL_U    = 3'd3;
  localparam logic [IMM_W-1:0] IMM_SEL_J    = 3'd4;
  localparam logic [IMM_W-1:0] IMM_SEL_NONE = 3'd7;

  // What the execute cycle has to enable for a given instruction
  typedef enum logic [2:0] {
    CL_ALU     = 3'd0,  // result to rd, advance PC
    CL_BRANCH  = 3'd1,  // PC only
    CL_STORE   = 3'd2,  // data-port write, advance PC
    CL_LOAD    = 3'd3,  // data-port read, writeback next cycle
    CL_CSR     = 3'd4,  // CSR write plus rd write
    CL_MRET    = 3'd5,  // PC only (return from trap)
    CL_ILLEGAL = 3'd6   // flagged, executed as NOP
  } op_class_t;

endpackage

// File: rtl/otter_cu_fsm_if.sv
// Control bundle between the decoder/CSR file/datapath and the control unit.
// master = control unit, slave = datapath side.
interface otter_cu_fsm_if;
  import otter_cu_fsm_pkg::*;

  logic [6:0]       opcode;
  logic [2:0]       funct3;
  logic             intr;
  logic             csr_mie;
  logic             rst_out;
  logic             pc_write;
  logic             reg_write;
  logic             mem_rden1;
  logic             mem_rden2;
  logic             mem_we2;
  logic             csr_we;
  logic             int_taken;
  logic [IMM_W-1:0] imm_sel;
  logic             illegal;

  modport master (
    input  opcode, funct3, intr, csr_mie,
    output rst_out, pc_write, reg_write, mem_rden1, mem_rden2, mem_we2,
           csr_we, int_taken, imm_sel, illegal
  );

  modport slave (
    output opcode, funct3, intr, csr_mie,
    input  rst_out, pc_write, reg_write, mem_rden1, mem_rden2, mem_we2,
           csr_we, int_taken, imm_sel, illegal
  );

endinterface

// File: rtl/otter_cu_fsm_op_class.sv
// Combinational opcode/funct3 decode into the immediate select and the
// instruction class the sequencer acts on.
module otter_op_class
  import otter_cu_fsm_pkg::*;
(
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  output logic [IMM_W-1:0] imm_sel,
  output op_class_t        op_class
);

  // Classify the instruction; anything unrecognised is illegal with no immediate
  always_comb begin
    imm_sel  = IMM_SEL_NONE;
    op_class = CL_ILLEGAL;
    case (opcode)
      OP_LUI, OP_AUIPC: begin imm_sel = IMM_SEL_U;    op_class = CL_ALU;    end
      OP_JAL:           begin imm_sel = IMM_SEL_J;    op_class = CL_ALU;    end
      OP_JALR, OP_IMM:  begin imm_sel = IMM_SEL_I;    op_class = CL_ALU;    end
      OP_OP:            begin imm_sel = IMM_SEL_NONE; op_class = CL_ALU;    end
      OP_BRANCH:        begin imm_sel = IMM_SEL_B;    op_class = CL_BRANCH; end
      OP_STORE:         begin imm_sel = IMM_SEL_S;    op_class = CL_STORE;  end
      OP_LOAD:          begin imm_sel = IMM_SEL_I;    op_class = CL_LOAD;   end
      OP_SYS: begin
        imm_sel = IMM_SEL_NONE;
        // funct3 == 0 in SYSTEM is MRET here; everything else is a CSR op
        if (funct3 != 3'd0) begin
          op_class = CL_CSR;
        end else begin
          op_class = CL_MRET;
        end
      end
      default: begin imm_sel = IMM_SEL_NONE; op_class = CL_ILLEGAL; end
    endcase
  end

endmodule

// File: rtl/otter_cu_fsm.sv
// Multicycle control sequencer for the Otter RV32I core:
// INIT -> FETCH -> EXEC [-> WB] [-> INTR] -> FETCH.
// Execute-cycle outputs are Mealy on the opcode held in the IR.
module otter_cu_fsm
  import otter_cu_fsm_pkg::*;
#(
  parameter int unsigned RESET_CYCLES = 1,
  parameter bit          INTR_EN      = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  otter_cu_fsm_if.master  cu
);

  // Clamp to the supported 1..15 range so the 4-bit counter can always terminate
  localparam int unsigned RC_CLAMP  = (RESET_CYCLES < 1) ? 1 : ((RESET_CYCLES > 15) ? 15 : RESET_CYCLES);
  localparam logic [3:0]  INIT_LAST = 4'(RC_CLAMP - 1);

  logic [2:0]       state;
  logic [2:0]       state_nxt;
  logic [3:0]       init_cnt;
  logic [3:0]       init_cnt_nxt;
  logic [IMM_W-1:0] dec_imm_sel;
  op_class_t        dec_class;
  logic             pend;

  otter_op_class u_op_class (
    .opcode   (cu.opcode),
    .funct3   (cu.funct3),
    .imm_sel  (dec_imm_sel),
    .op_class (dec_class)
  );

  // Interrupt is taken only at an instruction boundary and only if enabled globally
  assign pend = INTR_EN & cu.intr & cu.csr_mie;

  // State and init counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_INIT;
      init_cnt <= 4'd0;
    end else begin
      state    <= state_nxt;
      init_cnt <= init_cnt_nxt;
    end
  end

  // Init counter: counts up while in INIT, saturating at the last init cycle
  always_comb begin
    init_cnt_nxt = 4'd0;
    if (state == ST_INIT) begin
      if (init_cnt != INIT_LAST) begin
        init_cnt_nxt = init_cnt + 4'd1;
      end else begin
        init_cnt_nxt = init_cnt;
      end
    end else begin
      init_cnt_nxt = 4'd0;
    end
  end

  // Next-state logic; loads always finish their writeback before an interrupt
  always_comb begin
    state_nxt = ST_INIT;
    case (state)
      ST_INIT: begin
        if (init_cnt == INIT_LAST) begin
          state_nxt = ST_FETCH;
        end else begin
          state_nxt = ST_INIT;
        end
      end
      ST_FETCH: state_nxt = ST_EXEC;
      ST_EXEC: begin
        if (dec_class == CL_LOAD) begin
          state_nxt = ST_WB;
        end else if (pend) begin
          state_nxt = ST_INTR;
        end else begin
          state_nxt = ST_FETCH;
        end
      end
      ST_WB: begin
        if (pend) begin
          state_nxt = ST_INTR;
        end else begin
          state_nxt = ST_FETCH;
        end
      end
      ST_INTR: state_nxt = ST_FETCH;
      default: state_nxt = ST_INIT;
    endcase
  end

  // Output decode; unused state codes drive the idle (all-off) pattern
  always_comb begin
    cu.rst_out   = 1'b0;
    cu.pc_write  = 1'b0;
    cu.reg_write = 1'b0;
    cu.mem_rden1 = 1'b0;
    cu.mem_rden2 = 1'b0;
    cu.mem_we2   = 1'b0;
    cu.csr_we    = 1'b0;
    cu.int_taken = 1'b0;
    cu.imm_sel   = IMM_SEL_NONE;
    cu.illegal   = 1'b0;
    case (state)
      ST_INIT:  cu.rst_out   = 1'b1;
      ST_FETCH: cu.mem_rden1 = 1'b1;
      ST_EXEC: begin
        cu.imm_sel = dec_imm_sel;
        case (dec_class)
          CL_ALU:     begin cu.reg_write = 1'b1; cu.pc_write = 1'b1; end
          CL_BRANCH:  cu.pc_write  = 1'b1;
          CL_STORE:   begin cu.mem_we2 = 1'b1; cu.pc_write = 1'b1; end
          CL_LOAD:    cu.mem_rden2 = 1'b1;
          CL_CSR:     begin cu.csr_we = 1'b1; cu.reg_write = 1'b1; cu.pc_write = 1'b1; end
          CL_MRET:    cu.pc_write  = 1'b1;
          CL_ILLEGAL: begin cu.illegal = 1'b1; cu.pc_write = 1'b1; end
          default:    begin cu.illegal = 1'b1; cu.pc_write = 1'b1; end
        endcase
      end
      ST_WB: begin
        // imm_sel stays on I so the load address mux is stable during writeback
        cu.reg_write = 1'b1;
        cu.pc_write  = 1'b1;
        cu.imm_sel   = IMM_SEL_I;
      end
      ST_INTR: begin
        cu.int_taken = 1'b1;
        cu.pc_write  = 1'b1;
      end
      default: cu.imm_sel = IMM_SEL_NONE;
    endcase
  end

endmodule

// File: tb/tb_otter_cu_fsm.sv
// Self-checking bench for otter_cu_fsm: directed scenarios plus randomised
// instruction streams compared against a per-instruction cycle model.
module tb_otter_cu_fsm;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  otter_cu_fsm_if bus ();

  otter_cu_fsm #(.RESET_CYCLES(2), .INTR_EN(1'b1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .cu    (bus)
  );

  always #5 clk = ~clk;

  // Output vector: {rst_out,pc_write,reg_write,mem_rden1,mem_rden2,mem_we2,csr_we,int_taken,imm_sel[2:0],illegal}
  localparam logic [11:0] V_RESET = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd7, 1'b0};
  localparam logic [11:0] V_FETCH = {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd7, 1'b0};
  localparam logic [11:0] V_WB    = {1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0};
  localparam logic [11:0] V_INTR  = {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd7, 1'b0};

  function automatic logic [11:0] obs();
    return {bus.rst_out, bus.pc_write, bus.reg_write, bus.mem_rden1, bus.mem_rden2,
            bus.mem_we2, bus.csr_we, bus.int_taken, bus.imm_sel, bus.illegal};
  endfunction

  // Reference: what the execute cycle must show for an instruction, straight from the opcode table
  function automatic logic [11:0] exp_exec(input logic [6:0] op, input logic [2:0] f3);
    logic pc = 1'b0, rw = 1'b0, rd2 = 1'b0, we2 = 1'b0, cw = 1'b0, ill = 1'b0;
    logic [2:0] imm = 3'd7;
    case (op)
      7'h37, 7'h17: begin imm = 3'd3; rw = 1'b1; pc = 1'b1; end
      7'h6F:        begin imm = 3'd4; rw = 1'b1; pc = 1'b1; end
      7'h67, 7'h13: begin imm = 3'd0; rw = 1'b1; pc = 1'b1; end
      7'h33:        begin imm = 3'd7; rw = 1'b1; pc = 1'b1; end
      7'h63:        begin imm = 3'd2; pc = 1'b1; end
      7'h23:        begin imm = 3'd1; we2 = 1'b1; pc = 1'b1; end
      7'h03:        begin imm = 3'd0; rd2 = 1'b1; end
      7'h73:        begin pc = 1'b1; if (f3 != 3'd0) begin cw = 1'b1; rw = 1'b1; end end
      default:      begin ill = 1'b1; pc = 1'b1; end
    endcase
    return {1'b0, pc, rw, 1'b0, rd2, we2, cw, 1'b0, imm, ill};
  endfunction

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  // Run one instruction from FETCH to its next FETCH, checking every cycle
  task automatic do_instr(input logic [6:0] op, input logic [2:0] f3,
                          input logic irq, input logic mie, input string tag);
    logic [11:0] e;
    bus.opcode  = op;
    bus.funct3  = f3;
    bus.intr    = irq;
    bus.csr_mie = mie;
    @(negedge clk);
    n_checks++;
    if (obs() !== V_FETCH) begin
      n_fail++;
      $display("FAIL %s_fetch: got %h expected %h", tag, obs(), V_FETCH);
    end
    adv();
    @(negedge clk);
    e = exp_exec(op, f3);
    n_checks++;
    if (obs() !== e) begin
      n_fail++;
      $display("FAIL %s_exec op=%h f3=%0d: got %h expected %h", tag, op, f3, obs(), e);
    end
    adv();
    if (op == 7'h03) begin
      @(negedge clk);
      n_checks++;
      if (obs() !== V_WB) begin
        n_fail++;
        $display("FAIL %s_wb: got %h expected %h", tag, obs(), V_WB);
      end
      adv();
    end
    if (irq && mie) begin
      @(negedge clk);
      n_checks++;
      if (obs() !== V_INTR) begin
        n_fail++;
        $display("FAIL %s_intr: got %h expected %h", tag, obs(), V_INTR);
      end
      adv();
    end
    bus.intr = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.opcode = 7'h13; bus.funct3 = 3'd0; bus.intr = 1'b0; bus.csr_mie = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (obs() !== V_RESET) begin
      n_fail++;
      $display("FAIL reset_hold: got %h expected %h", obs(), V_RESET);
    end
    adv();
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_checks++;
      if (obs() !== V_RESET) begin
        n_fail++;
        $display("FAIL init_cycle%0d: got %h expected %h", i, obs(), V_RESET);
      end
      adv();
    end
  endtask

  task automatic test_directed();
    do_instr(7'h13, 3'd0, 1'b0, 1'b0, "addi");
    do_instr(7'h03, 3'd2, 1'b0, 1'b0, "lw");
    do_instr(7'h23, 3'd2, 1'b0, 1'b0, "sw");
    do_instr(7'h63, 3'd0, 1'b0, 1'b0, "beq");
    do_instr(7'h6F, 3'd0, 1'b0, 1'b0, "jal");
    do_instr(7'h37, 3'd0, 1'b0, 1'b0, "lui");
    do_instr(7'h33, 3'd0, 1'b0, 1'b0, "add");
    do_instr(7'h73, 3'd1, 1'b0, 1'b0, "csrrw");
    do_instr(7'h73, 3'd0, 1'b0, 1'b0, "mret");
    do_instr(7'h7F, 3'd0, 1'b0, 1'b0, "illegal");
  endtask

  task automatic test_interrupt();
    do_instr(7'h03, 3'd2, 1'b1, 1'b1, "lw_irq");
    do_instr(7'h13, 3'd0, 1'b1, 1'b1, "addi_irq");
    do_instr(7'h13, 3'd0, 1'b1, 1'b0, "addi_irq_masked");
    do_instr(7'h23, 3'd0, 1'b1, 1'b1, "sw_irq");
  endtask

  task automatic test_random();
    logic [6:0] ops [10] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h73};
    logic [6:0] op;
    for (int k = 0; k < 60; k++) begin
      if ($urandom_range(0, 3) == 0) op = 7'($urandom);
      else op = ops[$urandom_range(0, 9)];
      do_instr(op, 3'($urandom), ($urandom_range(0, 3) == 0), 1'($urandom), "rand");
    end
  endtask

  task automatic test_reset_mid_wb();
    bus.opcode = 7'h03; bus.funct3 = 3'd2; bus.intr = 1'b0; bus.csr_mie = 1'b0;
    adv();  // FETCH
    adv();  // EXEC
    @(negedge clk);
    n_checks++;
    if (obs() !== V_WB) begin
      n_fail++;
      $display("FAIL midwb_pre: got %h expected %h", obs(), V_WB);
    end
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if (obs() !== V_RESET) begin
      n_fail++;
      $display("FAIL midwb_async: got %h expected %h", obs(), V_RESET);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_checks++;
      if (obs() !== V_RESET) begin
        n_fail++;
        $display("FAIL midwb_init%0d: got %h expected %h", i, obs(), V_RESET);
      end
      adv();
    end
    do_instr(7'h13, 3'd0, 1'b0, 1'b0, "after_reset");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_interrupt();
    test_random();
    test_reset_mid_wb();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
